// File: rtl/counter_4bit_pkg.sv
// Shared constants and helpers for the counter_4bit block and its bench.
package counter_4bit_pkg;

    localparam int unsigned COUNTER_4BIT_DEFAULT_WIDTH = 4;

    // All-ones value for a counter of the given width (2^width - 1), width in 1..32.
    function automatic logic [31:0] max_count(input int unsigned width);
        return 32'hFFFF_FFFF >> (32 - width);
    endfunction

endpackage

// File: rtl/counter_4bit_tc_detect.sv
// Terminal-count detector: high when the counter sits at its maximum and is enabled.
module counter_4bit_tc_detect
    import counter_4bit_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_4BIT_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             enable_i,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] MaxCount = WIDTH'(max_count(WIDTH));

    assign tc_o = enable_i && (count_i == MaxCount);

endmodule

// File: rtl/counter_4bit.sv
// Free-running up-counter with count enable and asynchronous active-low reset.
// Define COUNTER_4BIT_STATUS_EN to add the tc (terminal count) and wrap (rollover) outputs.
module counter_4bit
    import counter_4bit_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_4BIT_DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
`ifdef COUNTER_4BIT_STATUS_EN
    output logic             tc_o,
    output logic             wrap_o,
`endif
    output logic [WIDTH-1:0] count_o
);

    if (WIDTH == 0 || WIDTH > 32) begin : gen_width_check
        $error("counter_4bit: WIDTH must be in 1..32");
    end

    logic [WIDTH-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (enable_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

`ifdef COUNTER_4BIT_STATUS_EN
    logic tc;
    logic wrap_d, wrap_q;

    counter_4bit_tc_detect #(
        .WIDTH (WIDTH)
    ) u_tc_detect (
        .count_i  (count_q),
        .enable_i (enable_i),
        .tc_o     (tc)
    );

    // A rollover happens on exactly the edges where tc is high.
    assign wrap_d = tc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign tc_o   = tc;
    assign wrap_o = wrap_q;
`endif

endmodule

// File: tb/tb_counter_4bit.sv
// Self-checking bench for counter_4bit: directed vector tables plus randomized run vs. a model.
module tb_counter_4bit;
    import counter_4bit_pkg::*;

    localparam int unsigned W   = 4;
    localparam int          MOD = 1 << W;
    localparam int          MAX = int'(max_count(W));

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         enable_i;
    logic [W-1:0] count_o;
`ifdef COUNTER_4BIT_STATUS_EN
    logic         tc_o;
    logic         wrap_o;
`endif

    counter_4bit #(
        .WIDTH (W)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .enable_i (enable_i),
`ifdef COUNTER_4BIT_STATUS_EN
        .tc_o     (tc_o),
        .wrap_o   (wrap_o),
`endif
        .count_o  (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic rst_n;
        logic en;
        int   cnt;
        logic tc;
        logic wrap;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   m_cnt  = 0;
    bit   m_wrap = 1'b0;

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input int cnt, input bit tc, input bit wrap);
        check_val({tag, " count"}, int'(count_o), cnt);
`ifdef COUNTER_4BIT_STATUS_EN
        check_val({tag, " tc"}, int'(tc_o), int'(tc));
        check_val({tag, " wrap"}, int'(wrap_o), int'(wrap));
`endif
    endtask

    // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic cycle(input logic rst_n, input logic en);
        rst_ni   = rst_n;
        enable_i = en;
        @(posedge clk_i);
        if (rst_ni && $isunknown(enable_i)) begin
            errors++;
            $display("FAIL enable_x: got X, expected 0 or 1 (t=%0t)", $time);
        end
        if (!rst_n) begin
            m_cnt  = 0;
            m_wrap = 1'b0;
        end else if (en) begin
            m_wrap = ((m_cnt + 1) % MOD) == 0;
            m_cnt  = (m_cnt + 1) % MOD;
        end else begin
            m_wrap = 1'b0;
        end
        @(negedge clk_i);
    endtask

    task automatic add(input logic r, input logic e, input int c, input logic t, input logic w);
        vec_t v;
        v.rst_n = r;
        v.en    = e;
        v.cnt   = c;
        v.tc    = t;
        v.wrap  = w;
        vecs.push_back(v);
    endtask

    task automatic run_vectors(input string tag);
        foreach (vecs[i]) begin
            cycle(vecs[i].rst_n, vecs[i].en);
            check_outputs($sformatf("%s[%0d]", tag, i), vecs[i].cnt, vecs[i].tc, vecs[i].wrap);
        end
        vecs.delete();
    endtask

    // Assert reset between edges; outputs must clear before any clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst_ni = 1'b0;
        #1;
        check_outputs(tag, 0, 1'b0, 1'b0);
        m_cnt  = 0;
        m_wrap = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        logic en;
        rst_ni   = 1'b0;
        enable_i = 1'b0;
        @(negedge clk_i);

        // Power-on reset, release with enable high, hold, resume.
        add(1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) add(1'b1, 1'b1, i, 1'b0, 1'b0);
        add(1'b1, 1'b0, 10, 1'b0, 1'b0);
        add(1'b1, 1'b0, 10, 1'b0, 1'b0);
        add(1'b1, 1'b1, 11, 1'b0, 1'b0);
        add(1'b1, 1'b1, 12, 1'b0, 1'b0);
        run_vectors("seqA");

        async_reset("midcycle_reset");

        // Count through rollover, park at max with enable low, then roll over once more.
        for (int i = 1; i <= 20; i++) add(1'b1, 1'b1, i % 16, i == 15, i == 16);
        for (int i = 5; i <= 15; i++) add(1'b1, 1'b1, i, i == 15, 1'b0);
        for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 15, 1'b0, 1'b0);
        add(1'b1, 1'b1, 0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 0, 1'b0, 1'b0);
        run_vectors("seqB");

        // Randomized enables and occasional asynchronous resets against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset("rand_reset");
            end
            en = ($urandom_range(0, 3) != 0);
            cycle(1'b1, en);
            check_outputs($sformatf("rand[%0d]", n), m_cnt, (m_cnt == MAX) && en, m_wrap);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
